keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
// - Front end of the calculator keypad. Scans a 6-column x 4-row passive switch matrix
//   and synchronizes/debounces the switches.
// - Produces the level-type calc_pkg::buttons_t vector that feeds the button
//   edge/priority logic.
// - Drives column strobes, samples row returns, updates the button vector once per
//   debounced scan frame.
// PARAMETERS
// - SETTLE_CYCLES   default 16  clocks a column is driven before its rows are sampled;
//                               legal range >= 3
// - DEBOUNCE_FRAMES default 4   consecutive identical frames required before buttons_o
//                               changes; legal range >= 1
// PORTS
// - clk_i        in   1   system clock
// - rst_ni       in   1   asynchronous, active-low reset
// - rows_i       in   4   row returns; active-low (pulled up); asynchronous to clk_i
// - cols_o       out  6   column strobes; active-low one-hot; all-ones = idle
// - buttons_o    out  23  calc_pkg::buttons_t; debounced level, 1 = held
// - frame_done_o out  1   one-cycle pulse at the end of every scan frame
// BEHAVIOUR
// - Reset values: cols_o=6'b111111, buttons_o='0, frame_done_o=0.
//   - Internal state is also cleared: col=0, cycle count=0, candidate='0, stable
//     count=0.
//   - Reset asserted mid-scan takes effect immediately; no partial frame is
//     committed.
// - Input sync: rows_i passes through a 2-FF synchronizer before use.
// - Scan timing:
//   - Column c (0..5) is driven low for SETTLE_CYCLES+1 clocks.
//   - The synchronized rows are captured on the last clock of that window.
//   - Next clock: the next column is driven, with no idle gap.
//   - Frame = 6*(SETTLE_CYCLES+1) clocks; after column 5 the scan wraps to column 0.
// - Snapshot:
//   - Key index k = row*6 + col, with a key pressed when its row reads 0 during its
//     column's strobe.
//   - Mapping k -> field: 0 on, 1 off, 2 mem_rc, 3 mem_sub, 4 mem_add, 5 op_percent,
//     6 op_sqrt, 7 op_div, 8 op_mul, 9 op_sub, 10 op_add, 11 op_eq, 12 dot,
//     13..22 num_0..num_9.
//   - Index 23 (row 3, col 5) is unpopulated and always ignored.
// - Frame end (the clock the col-5 capture completes):
//   - frame_done_o pulses.
//   - The debouncer evaluates snapshot s as below.
// - Debouncer:
//   - s != cand: cand<=s, cnt<=1.
//   - s == cand: cnt<=cnt+1, saturating at DEBOUNCE_FRAMES.
//   - Whenever the new cnt equals DEBOUNCE_FRAMES: buttons_o<=cand (or s), registered.
//   - Press/release latency: the change is visible one clock after the frame_done_o
//     of the DEBOUNCE_FRAMES-th identical frame.
//   - A bounce inside any frame restarts the count.
// - Multiple simultaneous keys are reported as-is; priority resolution is downstream.
// - buttons_o changes only at frame boundaries and is otherwise held.
// - No handshake; consumers sample buttons_o at any clock.
// CONFIGURATION
// - GHOST_REJECT_EN defined:
//   - A snapshot with >= 3 keys set (index 23 excluded) is unreliable on a diode-less
//     matrix.
//   - For such a snapshot: cnt<=0, cand unchanged, buttons_o holds its last value.
//   - The next valid snapshot restarts counting, either at 1 (s != cand) or via
//     increment (s == cand).
// - GHOST_REJECT_EN undefined: every snapshot is debounced normally, regardless of key
//   count.
// TESTING (SETTLE_CYCLES=4, DEBOUNCE_FRAMES=4 -> 30-clock frame)
// - Reset:
//   - Stimulus: rst_ni low mid-frame, rows_i=4'b0000.
//   - Required: cols_o=6'b111111 and buttons_o=0 immediately.
//   - After release: cols_o steps 111110, 111101, ... every 5 clocks, and frame_done_o
//     fires every 30 clocks.
// - Single press:
//   - Stimulus: hold num_5 (k=18: row 3, col 0) clean.
//   - Required: buttons_o.num_5=1 after the 4th frame_done_o containing it.
//   - Release: clears after 4 more frames.
// - Bounce:
//   - Stimulus: toggle op_add (k=10) so it is present in frames 1,2, absent in 3,
//     present in 4-7.
//   - Required: buttons_o.op_add rises only after frame 7; nothing earlier.
// - Two keys:
//   - Stimulus: hold on (k=0) and num_0 (k=13) together.
//   - Required: both bits set in buttons_o after 4 frames.
// - Ghosting (GHOST_REJECT_EN defined):
//   - Stimulus: hold k=0, 1, 6 for 6 frames.
//   - Required: buttons_o stays 0.
//   - Without the macro: all three bits set after frame 4.
// - Index 23:
//   - Stimulus: row 3 low during the col-5 strobe only.
//   - Required: buttons_o remains 0 forever.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: matrix geometry and the debounced button vector.
package calc_pkg;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 6;
    localparam int unsigned NUM_KEYS = 23;

    // Bit k of the packed vector is key index k (on = bit 0, num_9 = bit 22).
    typedef struct packed {
        logic num_9;
        logic num_8;
        logic num_7;
        logic num_6;
        logic num_5;
        logic num_4;
        logic num_3;
        logic num_2;
        logic num_1;
        logic num_0;
        logic dot;
        logic op_eq;
        logic op_add;
        logic op_sub;
        logic op_mul;
        logic op_div;
        logic op_sqrt;
        logic op_percent;
        logic mem_add;
        logic mem_sub;
        logic mem_rc;
        logic off;
        logic on;
    } buttons_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and button-vector signals between the scanner and its surroundings.
interface keypad_scanner_if;

    logic [calc_pkg::ROWS-1:0] rows_i;
    logic [calc_pkg::COLS-1:0] cols_o;
    calc_pkg::buttons_t        buttons_o;
    logic                      frame_done_o;

    modport master (input rows_i, output cols_o, buttons_o, frame_done_o);
    modport slave  (output rows_i, input cols_o, buttons_o, frame_done_o);

endinterface

// File: rtl/keypad_scanner.sv
// 6x4 keypad matrix scanner with 2-FF row sync and frame-based debouncing.
// Optional GHOST_REJECT_EN: snapshots with three or more keys are discarded.
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    keypad_scanner_if.master  bus
);
    import calc_pkg::*;

    localparam int unsigned CYC_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned COL_W  = 3;
    localparam int unsigned SNAP_W = ROWS * COLS;

    logic [ROWS-1:0]     rows_s1;
    logic [ROWS-1:0]     rows_s2;
    logic [COL_W-1:0]    col;
    logic [CYC_W-1:0]    cyc;
    logic [SNAP_W-1:0]   snap;
    logic [SNAP_W-1:0]   snap_next;
    logic [NUM_KEYS-1:0] frame_snap;
    logic [NUM_KEYS-1:0] cand;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                accept;

    // Row synchronizer; idle rows read high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_s1 <= '1;
            rows_s2 <= '1;
        end else begin
            rows_s1 <= bus.rows_i;
            rows_s2 <= rows_s1;
        end
    end

    // Current column's row returns merged into the running snapshot
    always_comb begin
        snap_next = snap;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (col == COL_W'(c)) begin
                    snap_next[r*COLS + c] = ~rows_s2[r];
                end
            end
        end
    end

    // Column strobe sequencing; all-ones strobe means the scan has not started yet
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.cols_o       <= '1;
            bus.frame_done_o <= 1'b0;
            col              <= '0;
            cyc              <= '0;
            snap             <= '0;
            frame_snap       <= '0;
        end else begin
            bus.frame_done_o <= 1'b0;
            if (bus.cols_o == '1) begin
                bus.cols_o <= ~COLS'(1);
                col        <= '0;
                cyc        <= '0;
            end else if (cyc == CYC_W'(SETTLE_CYCLES)) begin
                snap <= snap_next;
                cyc  <= '0;
                if (col == COL_W'(COLS - 1)) begin
                    col              <= '0;
                    bus.cols_o       <= ~COLS'(1);
                    frame_snap       <= snap_next[NUM_KEYS-1:0];
                    bus.frame_done_o <= 1'b1;
                end else begin
                    col        <= col + COL_W'(1);
                    bus.cols_o <= {bus.cols_o[COLS-2:0], 1'b1};
                end
            end else begin
                cyc <= cyc + CYC_W'(1);
            end
        end
    end

`ifdef GHOST_REJECT_EN
    localparam int unsigned KC_W = $clog2(NUM_KEYS + 1);
    logic [KC_W-1:0] key_cnt;

    // Three or more keys on a diode-less matrix may include phantom presses
    always_comb begin
        key_cnt = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            key_cnt = key_cnt + KC_W'(frame_snap[k]);
        end
        accept = (key_cnt < KC_W'(3));
    end
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        if (frame_snap != cand) begin
            cnt_next = CNT_W'(1);
        end else if (cnt == CNT_W'(DEBOUNCE_FRAMES)) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Debouncer evaluates the frame snapshot the clock after frame_done_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand          <= '0;
            cnt           <= '0;
            bus.buttons_o <= '0;
        end else if (bus.frame_done_o) begin
            if (!accept) begin
                cnt <= '0;
            end else begin
                cand <= frame_snap;
                cnt  <= cnt_next;
                if (cnt_next == CNT_W'(DEBOUNCE_FRAMES)) begin
                    bus.buttons_o <= buttons_t'(frame_snap);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_FRAMES=4 (30-clock frame).
module tb_keypad_scanner;

`ifdef GHOST_REJECT_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        override;
    logic [23:0] keys;
    logic [22:0] prev_exp;
    int          pass_cnt;
    int          total_cnt;
    int          first_fd;
    int          second_fd;
    logic [5:0]  exp_col;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_FRAMES (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (kif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive switch matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        kif.rows_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (keys[r*6 + c] && !kif.cols_o[c]) kif.rows_i[r] = 1'b0;
            end
        end
        if (override) kif.rows_i = 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (kif.frame_done_o) seen = 1'b1;
        end
        if (!seen) check("fd_timeout", 32'(kif.frame_done_o), 32'd1);
    endtask

    // One frame with the given keys held; checks hold at the pulse and value one clock later
    task automatic step_frame(input logic [23:0] k, input logic [22:0] exp, input string tag);
        keys = k;
        wait_fd();
        check({tag, "_hold"}, 32'(kif.buttons_o), 32'(prev_exp));
        @(negedge clk);
        check(tag, 32'(kif.buttons_o), 32'(exp));
        prev_exp = exp;
    endtask

    localparam logic [23:0] K_ON   = 24'h000001;
    localparam logic [23:0] K_OFF  = 24'h000002;
    localparam logic [23:0] K_SQRT = 24'h000040;
    localparam logic [23:0] K_ADD  = 24'h000400;
    localparam logic [23:0] K_N0   = 24'h002000;
    localparam logic [23:0] K_N5   = 24'h040000;
    localparam logic [23:0] K_23   = 24'h800000;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        first_fd  = 0;
        second_fd = 0;
        prev_exp  = '0;
        keys      = '0;
        override  = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All rows forced low: every key reads pressed
        repeat (4) wait_fd();
        @(negedge clk);
        check("all_keys", 32'(kif.buttons_o), GHOST ? 32'd0 : 32'h7FFFFF);

        // Async reset mid-frame
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_cols", 32'(kif.cols_o), 32'h3F);
        check("rst_buttons", 32'(kif.buttons_o), 32'd0);
        check("rst_fd", 32'(kif.frame_done_o), 32'd0);
        override = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cols_held", 32'(kif.cols_o), 32'h3F);
        rst_n = 1'b1;

        // Column stepping and frame period after release
        for (int i = 1; i <= 61; i++) begin
            @(negedge clk);
            if (i <= 26 && (i - 1) % 5 == 0) begin
                exp_col = ~(6'd1 << ((i - 1) / 5));
                check("col_step", 32'(kif.cols_o), 32'(exp_col));
            end
            if (kif.frame_done_o) begin
                if (first_fd == 0) first_fd = i;
                else if (second_fd == 0) second_fd = i;
            end
        end
        check("first_fd", 32'(first_fd), 32'd31);
        check("fd_period", 32'(second_fd - first_fd), 32'd30);

        // Single press of num_5 then release
        for (int f = 1; f <= 4; f++) step_frame(K_N5, (f == 4) ? K_N5[22:0] : 23'd0, "n5_press");
        for (int f = 1; f <= 4; f++) step_frame('0, (f == 4) ? 23'd0 : K_N5[22:0], "n5_release");

        // Bounce: present, present, absent, then four clean frames
        for (int f = 1; f <= 7; f++) begin
            step_frame((f == 3) ? 24'd0 : K_ADD, (f == 7) ? K_ADD[22:0] : 23'd0, "bounce");
        end
        for (int f = 1; f <= 4; f++) step_frame('0, (f == 4) ? 23'd0 : K_ADD[22:0], "add_release");

        // Two simultaneous keys
        for (int f = 1; f <= 4; f++) begin
            step_frame(K_ON | K_N0, (f == 4) ? 23'(K_ON | K_N0) : 23'd0, "two_keys");
        end
        for (int f = 1; f <= 4; f++) begin
            step_frame('0, (f == 4) ? 23'd0 : 23'(K_ON | K_N0), "two_release");
        end

        // Three keys: rejected with ghost filtering, reported otherwise
        for (int f = 1; f <= 6; f++) begin
            step_frame(K_ON | K_OFF | K_SQRT,
                       (!GHOST && f >= 4) ? 23'(K_ON | K_OFF | K_SQRT) : 23'd0, "ghost");
        end
        for (int f = 1; f <= 4; f++) begin
            step_frame('0, (!GHOST && f < 4) ? 23'(K_ON | K_OFF | K_SQRT) : 23'd0, "ghost_release");
        end

        // Unpopulated index 23 never reaches the button vector
        for (int f = 1; f <= 6; f++) step_frame(K_23, 23'd0, "idx23");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
